// File: rtl/layer_tile_scheduler.sv
// Walks one convolution layer through the PU controller as a sequence of tiles:
// OC tiles outer, IC tiles inner, one pu_start per tile and a wait for its total-finished pulse.
module layer_tile_scheduler #(
    parameter int IC_NUM_W   = 4,
    parameter int OC_NUM_W   = 4,
    parameter int IC_TILE    = 15,
    parameter int OC_TILE    = 15,
    parameter int LAYER_CH_W = 12,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  layer_start,
    input  logic [LAYER_CH_W-1:0] layer_IC,
    input  logic [LAYER_CH_W-1:0] layer_OC,
    input  logic                  pu_total_finished,
    output logic                  pu_start,
    output logic [IC_NUM_W-1:0]   pu_IC_Num,
    output logic [OC_NUM_W-1:0]   pu_OC_Num,
    output logic [LAYER_CH_W-1:0] tile_ic_base,
    output logic [LAYER_CH_W-1:0] tile_oc_base,
    output logic                  first_ic_tile,
    output logic                  last_ic_tile,
    output logic                  busy,
    output logic                  layer_done,
    output logic [CNT_W-1:0]      tile_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // One extra bit so base + tile never wraps in the end-of-dimension tests.
    localparam int EXT_W = LAYER_CH_W + 1;
    localparam logic [EXT_W-1:0]      IC_TILE_X = EXT_W'(IC_TILE);
    localparam logic [EXT_W-1:0]      OC_TILE_X = EXT_W'(OC_TILE);
    localparam logic [LAYER_CH_W-1:0] IC_TILE_L = LAYER_CH_W'(IC_TILE);
    localparam logic [LAYER_CH_W-1:0] OC_TILE_L = LAYER_CH_W'(OC_TILE);

    state_t                state_q, state_d;
    logic [LAYER_CH_W-1:0] layer_ic_q, layer_ic_d;
    logic [LAYER_CH_W-1:0] layer_oc_q, layer_oc_d;
    logic [LAYER_CH_W-1:0] ic_base_q, ic_base_d;
    logic [LAYER_CH_W-1:0] oc_base_q, oc_base_d;
    logic [CNT_W-1:0]      tile_count_q, tile_count_d;
    logic [IC_NUM_W-1:0]   ic_num_q, ic_num_d;
    logic [OC_NUM_W-1:0]   oc_num_q, oc_num_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;

    logic                  last_ic_now;
    logic                  last_oc_now;
    logic [LAYER_CH_W-1:0] ic_rem;
    logic [LAYER_CH_W-1:0] oc_rem;

    assign last_ic_now = ({1'b0, ic_base_q} + IC_TILE_X) >= {1'b0, layer_ic_q};
    assign last_oc_now = ({1'b0, oc_base_q} + OC_TILE_X) >= {1'b0, layer_oc_q};

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            layer_ic_q   <= '0;
            layer_oc_q   <= '0;
            ic_base_q    <= '0;
            oc_base_q    <= '0;
            tile_count_q <= '0;
            ic_num_q     <= '0;
            oc_num_q     <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_ic_q   <= layer_ic_d;
            layer_oc_q   <= layer_oc_d;
            ic_base_q    <= ic_base_d;
            oc_base_q    <= oc_base_d;
            tile_count_q <= tile_count_d;
            ic_num_q     <= ic_num_d;
            oc_num_q     <= oc_num_d;
            first_q      <= first_d;
            last_q       <= last_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    if ((layer_IC == '0) || (layer_OC == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (pu_total_finished) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (last_ic_now && last_oc_now) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bases, counters and the tile configuration presented with pu_start.
    always_comb begin
        layer_ic_d   = layer_ic_q;
        layer_oc_d   = layer_oc_q;
        ic_base_d    = ic_base_q;
        oc_base_d    = oc_base_q;
        tile_count_d = tile_count_q;
        ic_num_d     = ic_num_q;
        oc_num_d     = oc_num_q;
        first_d      = first_q;
        last_d       = last_q;
        ic_rem       = '0;
        oc_rem       = '0;

        if ((state_q == S_IDLE) && layer_start) begin
            layer_ic_d   = layer_IC;
            layer_oc_d   = layer_OC;
            ic_base_d    = '0;
            oc_base_d    = '0;
            tile_count_d = '0;
        end

        if ((state_q == S_WAIT) && pu_total_finished) begin
            tile_count_d = tile_count_q + CNT_W'(1);
        end

        if (state_q == S_ADVANCE) begin
            if (!last_ic_now) begin
                ic_base_d = ic_base_q + IC_TILE_L;
            end else begin
                ic_base_d = '0;
                oc_base_d = oc_base_q + OC_TILE_L;
            end
        end

        // Configuration is loaded from the upcoming bases so it is valid in the ISSUE cycle.
        if (state_d == S_ISSUE) begin
            ic_rem   = layer_ic_d - ic_base_d;
            oc_rem   = layer_oc_d - oc_base_d;
            ic_num_d = (ic_rem > IC_TILE_L) ? IC_NUM_W'(IC_TILE) : ic_rem[IC_NUM_W-1:0];
            oc_num_d = (oc_rem > OC_TILE_L) ? OC_NUM_W'(OC_TILE) : oc_rem[OC_NUM_W-1:0];
            first_d  = (ic_base_d == '0);
            last_d   = ({1'b0, ic_base_d} + IC_TILE_X) >= {1'b0, layer_ic_d};
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        pu_start   = 1'b0;
        busy       = 1'b1;
        layer_done = 1'b0;
        case (state_q)
            S_IDLE:  busy       = 1'b0;
            S_ISSUE: pu_start   = 1'b1;
            S_DONE:  layer_done = 1'b1;
            default: ;
        endcase
    end

    assign pu_IC_Num     = ic_num_q;
    assign pu_OC_Num     = oc_num_q;
    assign tile_ic_base  = ic_base_q;
    assign tile_oc_base  = oc_base_q;
    assign first_ic_tile = first_q;
    assign last_ic_tile  = last_q;
    assign tile_count    = tile_count_q;

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Scoreboard bench for layer_tile_scheduler: a driver pushes expected tiles and event
// cycles when it issues stimulus, and a negedge monitor pops and compares each event.
module tb_layer_tile_scheduler;

    localparam int IC_NUM_W   = 4;
    localparam int OC_NUM_W   = 4;
    localparam int IC_TILE    = 15;
    localparam int OC_TILE    = 15;
    localparam int LAYER_CH_W = 12;
    localparam int CNT_W      = 16;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  layer_start = 1'b0;
    logic [LAYER_CH_W-1:0] layer_IC = '0;
    logic [LAYER_CH_W-1:0] layer_OC = '0;
    logic                  pu_total_finished = 1'b0;
    logic                  pu_start;
    logic [IC_NUM_W-1:0]   pu_IC_Num;
    logic [OC_NUM_W-1:0]   pu_OC_Num;
    logic [LAYER_CH_W-1:0] tile_ic_base;
    logic [LAYER_CH_W-1:0] tile_oc_base;
    logic                  first_ic_tile;
    logic                  last_ic_tile;
    logic                  busy;
    logic                  layer_done;
    logic [CNT_W-1:0]      tile_count;

    layer_tile_scheduler #(
        .IC_NUM_W  (IC_NUM_W),
        .OC_NUM_W  (OC_NUM_W),
        .IC_TILE   (IC_TILE),
        .OC_TILE   (OC_TILE),
        .LAYER_CH_W(LAYER_CH_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .layer_start      (layer_start),
        .layer_IC         (layer_IC),
        .layer_OC         (layer_OC),
        .pu_total_finished(pu_total_finished),
        .pu_start         (pu_start),
        .pu_IC_Num        (pu_IC_Num),
        .pu_OC_Num        (pu_OC_Num),
        .tile_ic_base     (tile_ic_base),
        .tile_oc_base     (tile_oc_base),
        .first_ic_tile    (first_ic_tile),
        .last_ic_tile     (last_ic_tile),
        .busy             (busy),
        .layer_done       (layer_done),
        .tile_count       (tile_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int oc_base;
        int ic_base;
        int icn;
        int ocn;
        bit first;
        bit last;
        int tcount;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_total = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: enumerate the tile list directly from the layer dimensions.
    task automatic model_layer(input int ic, input int oc);
        int   n;
        exp_t e;
        n = 0;
        if (ic != 0 && oc != 0) begin
            for (int ob = 0; ob < oc; ob += OC_TILE) begin
                for (int ib = 0; ib < ic; ib += IC_TILE) begin
                    e.is_done = 1'b0;
                    e.oc_base = ob;
                    e.ic_base = ib;
                    e.icn     = (ic - ib < IC_TILE) ? ic - ib : IC_TILE;
                    e.ocn     = (oc - ob < OC_TILE) ? oc - ob : OC_TILE;
                    e.first   = (ib == 0);
                    e.last    = (ib + IC_TILE >= ic);
                    e.tcount  = n;
                    sb_q.push_back(e);
                    n++;
                end
            end
        end
        e = '{default: 0};
        e.is_done = 1'b1;
        e.tcount  = n;
        sb_q.push_back(e);
        exp_total = n;
    endtask

    // Monitor: compares every pu_start / layer_done against the scoreboard.
    int h_icb, h_ocb, h_icn, h_ocn, h_first, h_last;
    bit have_hold = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        int   ec;
        if (!reset) begin
            have_hold = 1'b0;
        end else if (pu_start || layer_done) begin
            if (cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL event_cycle: unexpected event at cycle %0d, expected none", cyc);
            end else begin
                ec = cyc_q.pop_front();
                chk("event_cycle", cyc, ec);
            end
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL event_kind: unexpected event (start=%0d done=%0d), expected none",
                         pu_start, layer_done);
            end else begin
                e = sb_q.pop_front();
                chk("event_kind", layer_done, e.is_done);
                chk("start_vs_done", pu_start, !e.is_done);
                chk("busy_in_event", busy, 1);
                chk("tile_count", tile_count, e.tcount);
                if (!e.is_done) begin
                    chk("tile_oc_base", tile_oc_base, e.oc_base);
                    chk("tile_ic_base", tile_ic_base, e.ic_base);
                    chk("pu_IC_Num", pu_IC_Num, e.icn);
                    chk("pu_OC_Num", pu_OC_Num, e.ocn);
                    chk("first_ic_tile", first_ic_tile, e.first);
                    chk("last_ic_tile", last_ic_tile, e.last);
                    $display("tile oc_base=%0d ic_base=%0d ic_num=%0d oc_num=%0d first=%0d last=%0d count=%0d",
                             tile_oc_base, tile_ic_base, pu_IC_Num, pu_OC_Num,
                             first_ic_tile, last_ic_tile, tile_count);
                end else begin
                    $display("layer_done tile_count=%0d", tile_count);
                end
            end
            h_icb     = tile_ic_base;
            h_ocb     = tile_oc_base;
            h_icn     = pu_IC_Num;
            h_ocn     = pu_OC_Num;
            h_first   = first_ic_tile;
            h_last    = last_ic_tile;
            have_hold = !layer_done;
        end else if (busy && have_hold) begin
            chk("hold_ic_base", tile_ic_base, h_icb);
            chk("hold_oc_base", tile_oc_base, h_ocb);
            chk("hold_ic_num", pu_IC_Num, h_icn);
            chk("hold_oc_num", pu_OC_Num, h_ocn);
            chk("hold_first", first_ic_tile, h_first);
            chk("hold_last", last_ic_tile, h_last);
        end
    end

    task automatic check_zero();
        chk("rst_pu_start", pu_start, 0);
        chk("rst_ic_num", pu_IC_Num, 0);
        chk("rst_oc_num", pu_OC_Num, 0);
        chk("rst_ic_base", tile_ic_base, 0);
        chk("rst_oc_base", tile_oc_base, 0);
        chk("rst_first", first_ic_tile, 0);
        chk("rst_last", last_ic_tile, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", layer_done, 0);
        chk("rst_tile_count", tile_count, 0);
    endtask

    // Drive one layer from an IDLE negedge; optionally poke ignored inputs along the way.
    task automatic run_layer(input int ic, input int oc, input bit poke);
        int guard;
        bit fin;
        guard = 0;
        fin   = 1'b0;
        model_layer(ic, oc);
        layer_IC    = LAYER_CH_W'(ic);
        layer_OC    = LAYER_CH_W'(oc);
        layer_start = 1'b1;
        cyc_q.push_back(cyc + 1);
        @(negedge clock);
        layer_start = 1'b0;
        while (!fin) begin
            if (layer_done) begin
                if (poke) pu_total_finished = 1'b1;
                @(negedge clock);
                pu_total_finished = 1'b0;
                fin = 1'b1;
            end else if (pu_start) begin
                if (poke) pu_total_finished = 1'b1;
                @(negedge clock);
                pu_total_finished = 1'b0;
                if (poke) begin
                    layer_IC    = LAYER_CH_W'($urandom_range(1, 4095));
                    layer_OC    = LAYER_CH_W'($urandom_range(1, 4095));
                    layer_start = 1'b1;
                    @(negedge clock);
                    layer_start = 1'b0;
                end
                repeat ($urandom_range(0, 3)) @(negedge clock);
                pu_total_finished = 1'b1;
                cyc_q.push_back(cyc + 2);
                @(negedge clock);
                pu_total_finished = 1'b0;
                @(negedge clock);
                guard = 0;
            end else begin
                guard++;
                if (guard > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL event_timeout: no pu_start or layer_done within 20 cycles, layer %0dx%0d", ic, oc);
                    fin = 1'b1;
                end else begin
                    @(negedge clock);
                end
            end
        end
        chk("idle_busy", busy, 0);
        chk("idle_layer_done", layer_done, 0);
        chk("idle_tile_count", tile_count, exp_total);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_zero();
        reset = 1'b1;
        @(negedge clock);

        run_layer(40, 20, 1'b0);
        run_layer(0, 7, 1'b0);
        run_layer(15, 15, 1'b1);
        run_layer(40, 20, 1'b1);

        // Asynchronous reset while the second tile is outstanding.
        model_layer(40, 20);
        layer_IC    = 12'd40;
        layer_OC    = 12'd20;
        layer_start = 1'b1;
        cyc_q.push_back(cyc + 1);
        @(negedge clock);
        layer_start = 1'b0;
        @(negedge clock);
        pu_total_finished = 1'b1;
        cyc_q.push_back(cyc + 2);
        @(negedge clock);
        pu_total_finished = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero();
        sb_q.delete();
        cyc_q.delete();
        repeat (2) @(negedge clock);
        check_zero();
        reset = 1'b1;
        @(negedge clock);
        run_layer(1, 1, 1'b0);

        // Back-to-back layers.
        run_layer(17, 31, 1'b0);
        run_layer(5, 3, 1'b0);

        repeat (20) begin
            int ric, roc;
            ric = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
            roc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
            run_layer(ric, roc, 1'($urandom_range(0, 1)));
        end
        run_layer(4095, 15, 1'b0);
        run_layer(30, 4095, 1'b0);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("cycle_queue_empty", cyc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_tile_scheduler.md
Name: layer_tile_scheduler

Overview:
Sequences one convolution layer through the processing unit (PU) controller.
- Splits the layer's input/output channel counts into PU-sized tiles.
- For each tile, issues a one-cycle start and drives the tile configuration (IC/OC count, channel bases, first/last flags for partial-sum accumulation).
- Waits for the PU's total-finished pulse before advancing.
- Loop order: OC tiles outer, IC tiles inner, so partial sums for one OC tile accumulate across all IC tiles before the next OC tile starts.

Parameters:
- IC_NUM_W, 4, width of pu_IC_Num; equals $clog2(`INPUT_CHANNEL).
- OC_NUM_W, 4, width of pu_OC_Num; equals $clog2(`OUTPUT_CHANNEL).
- IC_TILE, 15, maximum input channels per tile; must be ≤ 2^IC_NUM_W−1 and ≥1.
- OC_TILE, 15, maximum output channels per tile; must be ≤ 2^OC_NUM_W−1 and ≥1.
- LAYER_CH_W, 12, width of layer channel counts and channel bases.
- CNT_W, 16, width of tile_count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- layer_start  in  1  single-cycle request; sampled only in IDLE.
- layer_IC  in  LAYER_CH_W  layer input channels; latched at accepted layer_start.
- layer_OC  in  LAYER_CH_W  layer output channels; latched at accepted layer_start.
- pu_total_finished  in  1  one-cycle done pulse from the PU controller.
- pu_start  out  1  one-cycle tile start to the PU controller.
- pu_IC_Num  out  IC_NUM_W  input channels in the current tile.
- pu_OC_Num  out  OC_NUM_W  output channels in the current tile.
- tile_ic_base  out  LAYER_CH_W  first input channel of the current tile.
- tile_oc_base  out  LAYER_CH_W  first output channel of the current tile.
- first_ic_tile  out  1  current tile has ic_base==0 (accumulator clears).
- last_ic_tile  out  1  current tile is the final IC tile (accumulator writes out).
- busy  out  1  high in every state except IDLE.
- layer_done  out  1  one-cycle pulse at layer completion.
- tile_count  out  CNT_W  tiles completed in the current or most recent layer.

Behaviour:
- Reset (reset==0, asynchronous) forces state IDLE and every register to 0. Consequently all outputs read 0: pu_start, pu_IC_Num, pu_OC_Num, tile_ic_base, tile_oc_base, first_ic_tile, last_ic_tile, busy, layer_done, tile_count.
- Reset asserted mid-layer abandons the layer. No layer_done is produced. The next layer_start after reset deassertion is processed normally.
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE. pu_start, busy and layer_done decode from the state register only (Moore).
- IDLE:
  - On layer_start, latch layer_IC/layer_OC, clear ic_base, oc_base and tile_count.
  - If either latched dimension is 0, go to DONE; no pu_start is ever issued for that layer.
  - Otherwise go to ISSUE.
  - layer_start outside IDLE is ignored.
- ISSUE (exactly 1 cycle): pu_start=1, then go to WAIT.
- Tile configuration:
  - pu_IC_Num = min(IC_TILE, layer_IC−ic_base); pu_OC_Num = min(OC_TILE, layer_OC−oc_base).
  - first_ic_tile = (ic_base==0); last_ic_tile = (ic_base+IC_TILE ≥ layer_IC).
  - All configuration outputs are registered. They are valid in the ISSUE cycle and held stable through WAIT.
- WAIT: stay until pu_total_finished==1, then go to ADVANCE and increment tile_count. pu_total_finished in any other state is ignored.
- ADVANCE (1 cycle):
  - If not last_ic_tile: ic_base += IC_TILE.
  - Else ic_base=0 and oc_base += OC_TILE.
  - If the last IC tile of the last OC tile (oc_base+OC_TILE ≥ layer_OC) just completed, go to DONE; otherwise go to ISSUE.
- DONE (1 cycle): layer_done=1, busy=1, then go to IDLE.
- tile_count holds its final value until the next accepted layer_start.
- Arithmetic: base comparisons are computed one bit wider than LAYER_CH_W, so base+TILE never wraps.
- Latency:
  - layer_start sampled at edge N → pu_start in cycle N+1.
  - finish sampled at edge K → next pu_start in cycle K+2, or layer_done in cycle K+2.
  - Zero-dimension layer: layer_done in cycle N+1.
- Tile total per layer = ceil(layer_IC/IC_TILE) × ceil(layer_OC/OC_TILE).

Test Plan:
- layer_IC=40, layer_OC=20, default tiles → six pu_start pulses, each as (oc_base, ic_base, IC_Num, OC_Num, first, last): (0,0,15,15,1,0), (0,15,15,15,0,0), (0,30,10,15,0,1), (15,0,15,5,1,0), (15,15,15,5,0,0), (15,30,10,5,0,1); one layer_done 2 cycles after the 6th finish; tile_count=6.
- layer_IC=0, layer_OC=7 → no pu_start; busy and layer_done high exactly in the cycle after layer_start; tile_count=0.
- layer_IC=15, layer_OC=15 → single tile (0,0,15,15) with first_ic_tile=last_ic_tile=1; layer_done 2 cycles after finish.
- During WAIT, pulse layer_start with new dimensions; also pulse pu_total_finished during ISSUE and during DONE → no state or config change, latched dimensions unchanged, tile_count unaffected.
- Assert reset in WAIT of tile 2 → all outputs 0 immediately (asynchronous); after release, layer_IC=1, layer_OC=1 runs one tile (0,0,1,1) to layer_done.
- Back-to-back layers: layer_start asserted in the cycle following layer_done → accepted; tile_count restarts at 0; first pu_start 1 cycle later.
